// File: rtl/tlk2711_pkg.sv
// Shared TLK2711 link definitions: 18-bit {rkmsb,rklsb,rxd} K-words, deframer states, status codes.
package tlk2711_pkg;

  localparam logic [17:0] K_IDLE     = {2'b10, 16'hBC50};
  localparam logic [17:0] K_SOF      = {2'b11, 16'hFBFB};
  localparam logic [17:0] K_EOF      = {2'b11, 16'hFDFD};
  localparam logic [17:0] K_CODE_ERR = {2'b11, 16'hFEFE};

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_EOF
  } rx_state_e;

  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_LEN   = 3'd1;
  localparam logic [2:0] ERR_CSUM  = 3'd2;
  localparam logic [2:0] ERR_EOF   = 3'd3;
  localparam logic [2:0] ERR_KCHAR = 3'd4;
  localparam logic [2:0] ERR_SOF   = 3'd5;
  localparam logic [2:0] ERR_CODE  = 3'd6;

endpackage

// File: rtl/tlk2711_sat_cnt.sv
// Saturating statistics counter; a clear wins over a simultaneous increment.
module tlk2711_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/tlk2711_rx_deframer.sv
// TLK2711 receive deframer: word-sync hunt, SOF/LEN/payload/CSUM/EOF parsing, status and statistics.
// Optional TLK_RX_PATTERN_CHK_EN adds a counting-pattern payload checker (o_pattern_err_cnt).
module tlk2711_rx_deframer
  import tlk2711_pkg::*;
#(
  parameter int MAX_LEN    = 1024,
  parameter int LOCK_IDLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic             rx_clk,
  input  logic             rx_rstn,
  input  logic [15:0]      i_rxd,
  input  logic             i_rkmsb,
  input  logic             i_rklsb,
  input  logic             i_clr_cnt,
  output logic             o_link_up,
  output logic [15:0]      o_tdata,
  output logic             o_tvalid,
  output logic             o_tlast,
  output logic             o_frame_done,
  output logic             o_frame_err,
  output logic [2:0]       o_err_code,
`ifdef TLK_RX_PATTERN_CHK_EN
  output logic [CNT_W-1:0] o_pattern_err_cnt,
`endif
  output logic [CNT_W-1:0] o_frame_ok_cnt,
  output logic [CNT_W-1:0] o_frame_err_cnt,
  output logic [CNT_W-1:0] o_code_err_cnt
);

  localparam int          LK_W       = $clog2(LOCK_IDLES + 1);
  localparam logic [LK_W-1:0] LOCK_M1 = LK_W'(LOCK_IDLES - 1);
  localparam logic [15:0] MAX_LEN16  = 16'(MAX_LEN);

  logic [17:0] word_q;
  rx_state_e   state_q, state_n;
  logic [LK_W-1:0] idle_cnt_q, idle_cnt_n;
  logic [15:0] len_q, len_n, idx_q, idx_n, sum_q, sum_n;
  logic        csum_bad_q, csum_bad_n;
  logic        link_up_n, tvalid_n, tlast_n, done_n, err_n;
  logic [15:0] tdata_n;
  logic [2:0]  code_n;
  logic        cerr_inc;
  logic        w_idle, w_sof, w_eof, w_cerr, w_k, frame_open;
  logic [15:0] w_data;
`ifdef TLK_RX_PATTERN_CHK_EN
  logic        pat_inc;
`endif

  assign w_data     = word_q[15:0];
  assign w_k        = word_q[17] | word_q[16];
  assign w_idle     = (word_q == K_IDLE);
  assign w_sof      = (word_q == K_SOF);
  assign w_eof      = (word_q == K_EOF);
  assign w_cerr     = (word_q == K_CODE_ERR);
  assign frame_open = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                      (state_q == ST_CSUM) || (state_q == ST_EOF);

  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      word_q       <= '0;
      state_q      <= ST_HUNT;
      idle_cnt_q   <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      csum_bad_q   <= 1'b0;
      o_link_up    <= 1'b0;
      o_tdata      <= '0;
      o_tvalid     <= 1'b0;
      o_tlast      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_err_code   <= '0;
    end else begin
      word_q       <= {i_rkmsb, i_rklsb, i_rxd};
      state_q      <= state_n;
      idle_cnt_q   <= idle_cnt_n;
      len_q        <= len_n;
      idx_q        <= idx_n;
      sum_q        <= sum_n;
      csum_bad_q   <= csum_bad_n;
      o_link_up    <= link_up_n;
      o_tdata      <= tdata_n;
      o_tvalid     <= tvalid_n;
      o_tlast      <= tlast_n;
      o_frame_done <= done_n;
      o_frame_err  <= err_n;
      o_err_code   <= code_n;
    end
  end

  // CODE_ERR overrides every state; otherwise K-words in the middle of a frame abort it.
  always_comb begin
    state_n    = state_q;
    idle_cnt_n = idle_cnt_q;
    len_n      = len_q;
    idx_n      = idx_q;
    sum_n      = sum_q;
    csum_bad_n = csum_bad_q;
    link_up_n  = o_link_up;
    tdata_n    = o_tdata;
    tvalid_n   = 1'b0;
    tlast_n    = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    code_n     = ERR_OK;
    cerr_inc   = 1'b0;
`ifdef TLK_RX_PATTERN_CHK_EN
    pat_inc    = 1'b0;
`endif
    if (w_cerr) begin
      cerr_inc   = 1'b1;
      link_up_n  = 1'b0;
      state_n    = ST_HUNT;
      idle_cnt_n = '0;
      if (frame_open) begin
        done_n = 1'b1;
        err_n  = 1'b1;
        code_n = ERR_CODE;
      end
    end else begin
      unique case (state_q)
        ST_HUNT: begin
          if (!w_idle) begin
            idle_cnt_n = '0;
          end else if (idle_cnt_q == LOCK_M1) begin
            idle_cnt_n = '0;
            link_up_n  = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            idle_cnt_n = idle_cnt_q + LK_W'(1);
          end
        end
        ST_IDLE: begin
          if (w_sof) state_n = ST_LEN;
        end
        ST_LEN, ST_DATA, ST_CSUM: begin
          if (w_sof) begin
            done_n  = 1'b1;
            err_n   = 1'b1;
            code_n  = ERR_SOF;
            state_n = ST_LEN;
          end else if (w_k) begin
            done_n  = 1'b1;
            err_n   = 1'b1;
            code_n  = ERR_KCHAR;
            state_n = ST_IDLE;
          end else if (state_q == ST_LEN) begin
            if ((w_data != 16'd0) && (w_data <= MAX_LEN16)) begin
              len_n      = w_data;
              idx_n      = '0;
              sum_n      = '0;
              csum_bad_n = 1'b0;
              state_n    = ST_DATA;
            end else begin
              done_n  = 1'b1;
              err_n   = 1'b1;
              code_n  = ERR_LEN;
              state_n = ST_IDLE;
            end
          end else if (state_q == ST_DATA) begin
            tvalid_n = 1'b1;
            tdata_n  = w_data;
            sum_n    = sum_q + w_data;
            idx_n    = idx_q + 16'd1;
`ifdef TLK_RX_PATTERN_CHK_EN
            pat_inc  = (w_data != idx_q);
`endif
            if (idx_q == len_q - 16'd1) begin
              tlast_n = 1'b1;
              state_n = ST_CSUM;
            end
          end else begin
            csum_bad_n = (w_data != sum_q);
            state_n    = ST_EOF;
          end
        end
        ST_EOF: begin
          done_n = 1'b1;
          err_n  = 1'b1;
          if (w_sof) begin
            code_n  = ERR_SOF;
            state_n = ST_LEN;
          end else if (w_eof) begin
            err_n   = csum_bad_q;
            code_n  = csum_bad_q ? ERR_CSUM : ERR_OK;
            state_n = ST_IDLE;
          end else begin
            code_n  = ERR_EOF;
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_HUNT;
      endcase
    end
  end

  tlk2711_sat_cnt #(.CNT_W(CNT_W)) u_ok_cnt (
    .clk(rx_clk), .rst_n(rx_rstn), .inc(done_n & ~err_n), .clr(i_clr_cnt), .cnt(o_frame_ok_cnt)
  );

  tlk2711_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(rx_clk), .rst_n(rx_rstn), .inc(done_n & err_n), .clr(i_clr_cnt), .cnt(o_frame_err_cnt)
  );

  tlk2711_sat_cnt #(.CNT_W(CNT_W)) u_code_err_cnt (
    .clk(rx_clk), .rst_n(rx_rstn), .inc(cerr_inc), .clr(i_clr_cnt), .cnt(o_code_err_cnt)
  );

`ifdef TLK_RX_PATTERN_CHK_EN
  tlk2711_sat_cnt #(.CNT_W(CNT_W)) u_pattern_cnt (
    .clk(rx_clk), .rst_n(rx_rstn), .inc(pat_inc), .clr(i_clr_cnt), .cnt(o_pattern_err_cnt)
  );
`endif

endmodule
